// File: rtl/cnt_bank_pkg.sv
// Shared types and helpers for the counter bank scheduler.
//   state_e    : sweep FSM states (RUN, CLEAR)
//   cnt_word_t : counter word at the default width
//   idx_width  : index width for an n-entry bank (minimum 1 bit)
package cnt_bank_pkg;

  localparam int unsigned DEF_N   = 64;
  localparam int unsigned DEF_NCH = 4;
  localparam int unsigned DEF_IW  = 8;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef logic [DEF_N-1:0] cnt_word_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/brent_kung.sv
// Parallel-prefix (Brent-Kung) adder, W bits, carry-in and carry-out.
//   a_i, b_i : operands
//   cin_i    : carry in
//   sum_o    : a_i + b_i + cin_i mod 2^W
//   cout_o   : carry out of bit W-1
module brent_kung #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  localparam int unsigned L = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned P = 1 << L;

  logic [P-1:0] pb;
  logic [P-1:0] g;
  logic [P-1:0] p;
  logic [W-1:0] c;

  // Carry-in is folded into bit 0's generate so g[i] ends up as carry out of bit i.
  always_comb begin
    pb   = P'(a_i) ^ P'(b_i);
    g    = P'(a_i) & P'(b_i);
    p    = pb;
    g[0] = g[0] | (p[0] & cin_i);

    // Up-sweep: build group (g,p) at positions 2^k-1 strides.
    for (int lvl = 0; lvl < int'(L); lvl++) begin
      for (int i = (2 << lvl) - 1; i < int'(P); i += (2 << lvl)) begin
        g[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
        p[i] = p[i] & p[i - (1 << lvl)];
      end
    end

    // Down-sweep: fill in the remaining prefixes.
    for (int lvl = int'(L) - 2; lvl >= 0; lvl--) begin
      for (int i = (3 << lvl) - 1; i < int'(P); i += (2 << lvl)) begin
        g[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
        p[i] = p[i] & p[i - (1 << lvl)];
      end
    end

    c[0] = cin_i;
    for (int i = 1; i < int'(W); i++) begin
      c[i] = g[i-1];
    end

    sum_o  = pb[W-1:0] ^ c;
    cout_o = g[W-1];
  end

endmodule

// File: rtl/cnt_bank_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, cyclically.
//   req_i     : request vector
//   ptr_i     : highest-priority index this cycle
//   gnt_o     : one-hot grant (zero if no request)
//   gnt_idx_o : index of the granted requester
//   any_o     : a grant was issued
module rr_arbiter
  import cnt_bank_pkg::*;
#(
  parameter  int unsigned NCH  = 4,
  localparam int unsigned IDXW = idx_width(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NCH-1:0]  gnt_o,
  output logic [IDXW-1:0] gnt_idx_o,
  output logic            any_o
);

  // NCH is a power of two, so the index add wraps naturally.
  always_comb begin
    logic [IDXW-1:0] idx;
    idx       = '0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int off = 0; off < int'(NCH); off++) begin
      idx = ptr_i + IDXW'(off);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_idx_o  = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnt_bank_sched.sv
// Bank of NCH accumulating counters sharing one adder, round-robin request
// scheduling and a one-channel-per-cycle clear sweep.
// Optional build macro CNT_BANK_SAT_EN: saturate on carry-out instead of wrapping.
//   clk, nrst  : clock, async active-low reset
//   req_valid  : per-channel increment request
//   req_inc    : per-channel increment, channel i at [i*IW +: IW]
//   req_ready  : per-channel grant (combinational)
//   clr_start  : start clear sweep
//   clr_done   : one-cycle pulse on the first RUN cycle after a sweep
//   busy       : sweep in progress
//   rd_sel     : readback channel select
//   rd_data    : counter[rd_sel] (combinational)
//   rd_ovf     : sticky overflow of channel rd_sel (combinational)
module cnt_bank_sched
  import cnt_bank_pkg::*;
#(
  parameter int unsigned N   = DEF_N,
  parameter int unsigned NCH = DEF_NCH,
  parameter int unsigned IW  = DEF_IW
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*IW-1:0]       req_inc,
  output logic [NCH-1:0]          req_ready,
  input  logic                    clr_start,
  output logic                    clr_done,
  output logic                    busy,
  input  logic [$clog2(NCH)-1:0]  rd_sel,
  output logic [N-1:0]            rd_data,
  output logic                    rd_ovf
);

  localparam int unsigned IDXW = idx_width(NCH);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            clr_done_q, clr_done_d;

  logic [N-1:0]    cnt_q [NCH];
  logic [NCH-1:0]  ovf_q;

  logic [NCH-1:0]  gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            any_gnt;
  logic            xfer;

  logic [IW-1:0]   inc_sel;
  logic [N-1:0]    inc_ext;
  logic [N-1:0]    sum;
  logic            cout;
  logic [N-1:0]    new_val;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_gnt)
  );

  // Granted channel's increment; grant is one-hot so OR-reduce is a mux.
  always_comb begin
    inc_sel = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (gnt[i]) inc_sel = inc_sel | req_inc[i*IW +: IW];
    end
  end

  assign inc_ext = N'(inc_sel);

  brent_kung #(.W(N)) u_add (
    .a_i    (cnt_q[gnt_idx]),
    .b_i    (inc_ext),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

`ifdef CNT_BANK_SAT_EN
  assign new_val = cout ? '1 : sum;
`else
  assign new_val = sum;
`endif

  assign xfer = (state_q == RUN) && any_gnt;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= RUN;
      idx_q      <= '0;
      ptr_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Next-state logic: sweep sequencing and round-robin pointer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_done_d = 1'b0;
    ptr_d      = xfer ? (gnt_idx + IDXW'(1)) : ptr_q;
    unique case (state_q)
      RUN: begin
        if (clr_start) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        if (idx_q == IDXW'(NCH - 1)) begin
          state_d    = RUN;
          clr_done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    if (state_q == RUN) begin
      req_ready = gnt;
    end else begin
      busy = 1'b1;
    end
  end

  // Counter bank: sweep clear has priority; transfers only occur in RUN.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        if ((state_q == CLEAR) && (idx_q == IDXW'(i))) begin
          cnt_q[i] <= '0;
          ovf_q[i] <= 1'b0;
        end else if (xfer && (gnt_idx == IDXW'(i))) begin
          cnt_q[i] <= new_val;
          if (cout) ovf_q[i] <= 1'b1;
        end
      end
    end
  end

  assign clr_done = clr_done_q;
  assign rd_data  = cnt_q[rd_sel];
  assign rd_ovf   = ovf_q[rd_sel];

endmodule
